// File: rtl/input_mmio_if.sv
// CPU data-bus view of the input peripheral: load/store strobes, address, and the
// combinational read path (rdata/hit) returned to the core.
interface input_mmio_if;
   logic [31:0] addr;
   logic        rd_en;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        hit;

   modport master (output addr, rd_en, we, wdata, input rdata, hit);
   modport slave  (input addr, rd_en, we, wdata, output rdata, hit);
endinterface

// File: rtl/input_mmio.sv
// Memory-mapped button peripheral: 2-flop sync, per-button debounce, sticky press events.
// Optional feature macro INPUT_IRQ_EN adds the MASK register and a registered irq.
module input_mmio #(
   parameter int          N_BTN      = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
   parameter logic [19:0] DB_DEFAULT = 20'd500000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in,
   input_mmio_if.slave      bus,
   output logic             irq
);

   logic [N_BTN-1:0] s1_q, s2_q;
   logic [N_BTN-1:0] stable_q, stable_d;
   logic [19:0]      cnt_q [N_BTN];
   logic [19:0]      cnt_d [N_BTN];
   logic [N_BTN-1:0] events_q, events_d;
   logic [19:0]      t_q, t_d;
   logic [19:0]      teff_m1;
   logic [N_BTN-1:0] press;
   logic [N_BTN-1:0] mask_rd;
   logic [1:0]       offset;
   logic             rd_clr;
   logic             unused_bits;

   assign offset      = bus.addr[3:2];
   assign bus.hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign rd_clr      = bus.rd_en && bus.hit && (offset == 2'd1);
   assign unused_bits = ^{bus.addr[1:0], bus.wdata};

   // A threshold of 0 behaves as 1; >= lets a lowered threshold flip a long-running count at once.
   assign teff_m1 = (t_q == 20'd0) ? 20'd0 : t_q - 20'd1;

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic mism, done;
      assign mism         = s2_q[gi] ^ stable_q[gi];
      assign done         = mism && (cnt_q[gi] >= teff_m1);
      assign stable_d[gi] = done ? s2_q[gi] : stable_q[gi];
      assign cnt_d[gi]    = (!mism || done) ? 20'd0 : cnt_q[gi] + 20'd1;
   end

   assign press = stable_d & ~stable_q;

   always_comb begin
      bus.rdata = 32'd0;
      if (bus.hit) begin
         case (offset)
            2'd0:    bus.rdata = {{(32-N_BTN){1'b0}}, stable_q};
            2'd1:    bus.rdata = {{(32-N_BTN){1'b0}}, events_q};
            2'd2:    bus.rdata = {12'd0, t_q};
            default: bus.rdata = {{(32-N_BTN){1'b0}}, mask_rd};
         endcase
      end
   end

   // Set wins over clear: a press on the clearing edge survives.
   assign events_d = (events_q & ~(rd_clr ? bus.rdata[N_BTN-1:0] : {N_BTN{1'b0}})) | press;
   assign t_d      = (bus.we && bus.hit && offset == 2'd2) ? bus.wdata[19:0] : t_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q     <= '0;
         s2_q     <= '0;
         stable_q <= '0;
         events_q <= '0;
         t_q      <= DB_DEFAULT;
         for (int i = 0; i < N_BTN; i++) cnt_q[i] <= 20'd0;
      end else begin
         s1_q     <= btn_in;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         events_q <= events_d;
         t_q      <= t_d;
         for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
      end
   end

`ifdef INPUT_IRQ_EN
   logic [N_BTN-1:0] mask_q;
   logic             irq_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         if (bus.we && bus.hit && offset == 2'd3) mask_q <= bus.wdata[N_BTN-1:0];
         irq_q <= |(events_d & mask_q);
      end
   end

   assign mask_rd = mask_q;
   assign irq     = irq_q;
`else
   assign mask_rd = '0;
   assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_input_mmio.sv
// Randomized bench for input_mmio: a cycle-level reference model feeds a scoreboard queue
// that an independent monitor drains and compares against rdata/hit/irq.
module tb_input_mmio;
   localparam int          N    = 4;
   localparam logic [31:0] BASE = 32'h0000_0400;

   logic         clk   = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] btn   = '0;
   logic         irq;
   input_mmio_if bus ();

   input_mmio #(.N_BTN(N), .BASE_ADDR(BASE), .DB_DEFAULT(20'd500000)) dut (
      .clk(clk), .reset(reset), .btn_in(btn), .bus(bus), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        hit;
      logic        irq;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int passes = 0;
   int cyc_n  = 0;

   // Reference model state: what the peripheral should hold after each edge.
   logic [N-1:0] m_s1, m_s2, m_stable, m_events, m_mask;
   int           m_run [N];
   int           m_t;
   logic         m_irq;

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_events = '0; m_mask = '0;
      m_t = 500000; m_irq = 1'b0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
   endtask

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      if (a[31:4] != BASE[31:4]) return 32'd0;
      case (a[3:2])
         2'd0:    return 32'(m_stable);
         2'd1:    return 32'(m_events);
         2'd2:    return 32'(m_t);
         default: return 32'(m_mask);
      endcase
   endfunction

   task automatic model_edge(input logic [N-1:0] b, input logic [31:0] a,
                             input logic rd, input logic w, input logic [31:0] wd);
      int teff;
      logic [N-1:0] ns, press, ev;
      logic hitm;
      teff = (m_t == 0) ? 1 : m_t;
      ns   = m_stable;
      // A level is accepted once the synchronized input has disagreed for Teff edges in a row.
      for (int i = 0; i < N; i++) begin
         if (m_s2[i] == m_stable[i]) m_run[i] = 0;
         else if (m_run[i] >= teff - 1) begin ns[i] = m_s2[i]; m_run[i] = 0; end
         else m_run[i] = m_run[i] + 1;
      end
      press = ns & ~m_stable;
      hitm  = (a[31:4] == BASE[31:4]);
      ev    = m_events;
      if (rd && hitm && a[3:2] == 2'd1) ev = '0;
      ev = ev | press;
      if (w && hitm && a[3:2] == 2'd2) m_t = int'(wd[19:0]);
`ifdef INPUT_IRQ_EN
      m_irq = |(ev & m_mask);
      if (w && hitm && a[3:2] == 2'd3) m_mask = wd[N-1:0];
`endif
      m_events = ev;
      m_stable = ns;
      m_s2     = m_s1;
      m_s1     = b;
   endtask

   task automatic step(input logic r, input logic [N-1:0] b, input logic [31:0] a,
                       input logic rd, input logic w, input logic [31:0] wd);
      exp_t e;
      @(negedge clk);
      reset = r; btn = b;
      bus.addr = a; bus.rd_en = rd; bus.we = w; bus.wdata = wd;
      if (!r) model_reset();
      e.rdata = model_rd(a);
      e.hit   = (a[31:4] == BASE[31:4]);
      e.irq   = m_irq;
      e.cyc   = cyc_n;
      sb.push_back(e);
      cyc_n++;
      if (r) model_edge(b, a, rd, w, wd);
   endtask

   task automatic chk(input string nm, input int cyc, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) $display("FAIL %s cyc=%0d got=%08h exp=%08h", nm, cyc, got, expv);
      else passes++;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rdata", e.cyc, bus.rdata, e.rdata);
            chk("hit", e.cyc, 32'(bus.hit), 32'(e.hit));
            chk("irq", e.cyc, 32'(irq), 32'(e.irq));
         end
      end
   end

   initial begin : driver
      logic [N-1:0] b;
      logic [31:0]  a, wd;
      logic         r;
      bus.addr = '0; bus.rd_en = 1'b0; bus.we = 1'b0; bus.wdata = '0;
      model_reset();

      // Reset with btn0 already held, then T=4 and let it debounce.
      repeat (3) step(0, 4'h1, BASE, 1, 0, 0);
      step(1, 4'h1, BASE + 8, 0, 1, 32'd4);
      repeat (8) step(1, 4'h1, BASE, 1, 0, 0);
      step(1, 4'h1, BASE + 4, 1, 0, 0);
      step(1, 4'h1, BASE + 4, 1, 0, 0);

      // Glitches: 3-cycle pulse rejected, 4-cycle pulse accepted.
      repeat (3) step(1, 4'h3, BASE + 4, 0, 0, 0);
      repeat (8) step(1, 4'h1, BASE + 4, 0, 0, 0);
      repeat (4) step(1, 4'h3, BASE + 4, 0, 0, 0);
      repeat (8) step(1, 4'h1, BASE + 4, 0, 0, 0);

      // Read-clear racing a btn2 press completing on the same edge.
      step(1, 4'h5, BASE + 4, 0, 0, 0);
      repeat (4) step(1, 4'h5, BASE, 0, 0, 0);
      step(1, 4'h5, BASE + 4, 1, 0, 0);
      step(1, 4'h5, BASE + 4, 1, 0, 0);

      // DBCFG: T=0 behaves as 1; oversized write truncates; read+write returns old value.
      step(1, 4'h5, BASE + 8, 1, 1, 32'd0);
      repeat (3) step(1, 4'hD, BASE + 8, 1, 0, 0);
      repeat (3) step(1, 4'h5, BASE, 1, 0, 0);
      step(1, 4'h5, BASE + 8, 1, 1, 32'hFFFF_FFFF);
      step(1, 4'h5, BASE + 8, 1, 0, 0);
      step(1, 4'h5, BASE + 8, 0, 1, 32'd3);

      // Decode: out-of-window address, ignored store to STATE/EVENTS.
      step(1, 4'h5, BASE + 32'h10, 1, 0, 0);
      step(1, 4'h5, BASE, 1, 1, 32'hFFFF_FFFF);
      step(1, 4'h5, BASE + 4, 0, 1, 32'hFFFF_FFFF);
      step(1, 4'h5, BASE + 4, 1, 0, 0);

      // IRQ mask: only btn1 is enabled.
      step(1, 4'h0, BASE + 12, 1, 1, 32'h2);
      repeat (6) step(1, 4'h0, BASE + 12, 1, 0, 0);
      repeat (6) step(1, 4'h1, BASE + 4, 0, 0, 0);
      repeat (6) step(1, 4'h3, BASE + 4, 0, 0, 0);
      step(1, 4'h3, BASE + 4, 1, 0, 0);
      repeat (2) step(1, 4'h3, BASE + 4, 0, 0, 0);

      // Reset mid-debounce discards the count and the level.
      step(1, 4'h3, BASE + 8, 0, 1, 32'd6);
      repeat (4) step(1, 4'hB, BASE, 1, 0, 0);
      repeat (2) step(0, 4'hB, BASE, 1, 0, 0);
      step(1, 4'hB, BASE + 8, 0, 1, 32'd3);
      repeat (8) step(1, 4'hB, BASE, 1, 0, 0);

      // Randomized traffic.
      b = 4'hB;
      repeat (3000) begin
         if ($urandom_range(0, 5) == 0) b[$urandom_range(0, N-1)] ^= 1'b1;
         a = BASE + 32'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) a = $urandom;
         wd = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 6));
         r  = ($urandom_range(0, 499) != 0);
         step(r, b, a, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), wd);
      end
      repeat (3) step(1, b, BASE, 1, 0, 0);

      repeat (3) @(posedge clk);
      chk("sb_drain", cyc_n, 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
